// File: rtl/instruction_loader_pkg.sv
// Debug-unit constants shared by the instruction loader and its byte packer.
// Memory depth, terminating instruction and the loader state encoding.
package instruction_loader_pkg;

    localparam int unsigned DEPTH     = 32;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian byte-to-word packer: shift register plus mod-4 byte counter.
// word_valid_o pulses combinationally with the byte that completes a word.
module instruction_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] shift_q;
    logic [1:0]  byte_cnt_q;

    // The word as it will look once this byte is shifted in; the first byte lands in [31:24].
    assign word_o       = {shift_q[23:0], byte_i};
    assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);

    // NOTE: non-blocking assignments make every flop update see pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (clear_i) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (byte_valid_i) begin
            shift_q    <= word_o;
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a UART byte stream into instruction memory as 32-bit words at addresses 0, 1, 2, ...
// Stops after writing HALT_WORD or the last address, then holds load_done until restarted.
module instruction_loader #(
    parameter int unsigned DEPTH     = instruction_loader_pkg::DEPTH,
    parameter logic [31:0] HALT_WORD = instruction_loader_pkg::HALT_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_instruction,
    output logic [31:0] data_instruction,
    output logic [31:0] inst_addr,
    output logic        loading,
    output logic        load_done,
    output logic        mem_full,
    output logic [5:0]  word_count
);

    import instruction_loader_pkg::*;

    state_e      state_q;
    logic        wr_q;
    logic [31:0] data_q;
    logic [31:0] addr_q;
    logic        loading_q;
    logic        load_done_q;
    logic        mem_full_q;
    logic [5:0]  word_count_q;

    logic        halt_hit;
    logic        last_addr;
    logic        restart;
    logic        byte_accept;
    logic [31:0] packed_word;
    logic        word_valid;

    assign halt_hit  = (data_q == HALT_WORD);
    assign last_addr = (addr_q == 32'(DEPTH - 1));
    assign restart   = start && ((state_q == IDLE) || (state_q == DONE));

    // A byte arriving during WRITE starts the next word, unless this write ends the load.
    assign byte_accept = rx_valid &&
                         ((state_q == RECV) ||
                          ((state_q == WRITE) && !halt_hit && !last_addr));

    instruction_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (restart),
        .byte_valid_i (byte_accept),
        .byte_i       (rx_data),
        .word_o       (packed_word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            loading_q    <= 1'b0;
            load_done_q  <= 1'b0;
            mem_full_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RECV;
                        loading_q    <= 1'b1;
                        load_done_q  <= 1'b0;
                        addr_q       <= '0;
                        word_count_q <= '0;
                        mem_full_q   <= 1'b0;
                    end
                end
                RECV: begin
                    if (word_valid) begin
                        state_q <= WRITE;
                        wr_q    <= 1'b1;
                        data_q  <= packed_word;
                    end
                end
                WRITE: begin
                    word_count_q <= word_count_q + 6'd1;
                    if (halt_hit || last_addr) begin
                        state_q     <= DONE;
                        loading_q   <= 1'b0;
                        load_done_q <= 1'b1;
                        mem_full_q  <= !halt_hit;
                    end else begin
                        state_q <= RECV;
                        addr_q  <= addr_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_instruction   = wr_q;
    assign data_instruction = data_q;
    assign inst_addr        = addr_q;
    assign loading          = loading_q;
    assign load_done        = load_done_q;
    assign mem_full         = mem_full_q;
    assign word_count       = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus randomized loads,
// compared every cycle against a transaction-level model of the loader.
module tb_instruction_loader;

    import instruction_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wr_instruction;
    logic [31:0] data_instruction;
    logic [31:0] inst_addr;
    logic        loading;
    logic        load_done;
    logic        mem_full;
    logic [5:0]  word_count;

    instruction_loader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .wr_instruction   (wr_instruction),
        .data_instruction (data_instruction),
        .inst_addr        (inst_addr),
        .loading          (loading),
        .load_done        (load_done),
        .mem_full         (mem_full),
        .word_count       (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a load is either active (collecting bytes), writing, or finished.
    logic        m_active, m_done, m_wr, m_full;
    logic [31:0] m_word;
    int unsigned m_addr, m_count;
    logic [7:0]  m_bytes[$];

    // Writes observed on the DUT memory port since the log was last cleared.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_full = 1'b0;
        m_word = '0; m_addr = 0; m_count = 0;
        m_bytes.delete();
    endtask

    task automatic model_step(input logic s, input logic v, input logic [7:0] d);
        if (m_wr) begin
            m_wr = 1'b0;
            m_count++;
            if (m_word == HALT_WORD) begin
                m_active = 1'b0; m_done = 1'b1;
            end else if (m_addr == DEPTH - 1) begin
                m_active = 1'b0; m_done = 1'b1; m_full = 1'b1;
            end else begin
                m_addr++;
                if (v) m_bytes.push_back(d);
            end
        end else if (m_active) begin
            if (v) begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 4) begin
                    m_word = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_bytes.delete();
                    m_wr = 1'b1;
                end
            end
        end else if (s) begin
            m_active = 1'b1; m_done = 1'b0; m_full = 1'b0;
            m_addr = 0; m_count = 0;
            m_bytes.delete();
        end
    endtask

    task automatic compare();
        check("wr_instruction", wr_instruction, m_wr);
        check("loading", loading, m_active);
        check("load_done", load_done, m_done);
        check("mem_full", mem_full, m_full);
        check("inst_addr", inst_addr, m_addr);
        check("word_count", word_count, m_count);
        if (m_wr) check("data_instruction", data_instruction, m_word);
        if (wr_instruction) begin
            log_addr.push_back(inst_addr);
            log_data.push_back(data_instruction);
        end
    endtask

    // Inputs change at the negedge, the model steps at the posedge, outputs are checked at the next negedge.
    task automatic tick(input logic s, input logic v, input logic [7:0] d);
        start = s; rx_valid = v; rx_data = d;
        @(posedge clk);
        model_step(s, v, d);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tick(1'b0, 1'b1, w[8*i +: 8]);
    endtask

    task automatic send_word_gapped(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                tick(($urandom_range(0, 5) == 0), 1'b0, 8'($urandom()));
            tick(1'b0, 1'b1, w[8*i +: 8]);
        end
    endtask

    function automatic logic [31:0] non_halt_word();
        logic [31:0] w;
        w = $urandom();
        w[31] = 1'b0;
        return w;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        check("reset data_instruction", data_instruction, 32'h0);
        check("reset inst_addr", inst_addr, 32'h0);
        rst = 1'b1;

        // First word and its one-cycle write latency, then a HALT-terminated load of 4 words.
        clear_log();
        tick(1'b1, 1'b0, 8'h00);
        send_word(32'h0022_1820);
        check("first word wr", wr_instruction, 1'b1);
        check("first word data", data_instruction, 32'h0022_1820);
        check("first word addr", inst_addr, 32'd0);
        idle(1);
        check("first word count", word_count, 6'd1);
        idle(2);
        send_word(32'h8C01_0004);
        send_word(32'hAC02_0008);
        send_word(32'hFFFF_FFFF);
        idle(2);
        check("halt load_done", load_done, 1'b1);
        check("halt mem_full", mem_full, 1'b0);
        check("halt word_count", word_count, 6'd4);
        check("halt pulses", log_addr.size(), 32'd4);
        if (log_addr.size() == 4) begin
            check("back-to-back addr", log_addr[2], 32'd2);
            check("back-to-back data", log_data[2], 32'hAC02_0008);
            check("halt last data", log_data[3], 32'hFFFF_FFFF);
        end

        // Fill memory back to back; the 33rd word's bytes must not be written.
        clear_log();
        tick(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < DEPTH + 1; k++) send_word(non_halt_word());
        idle(3);
        check("full load_done", load_done, 1'b1);
        check("full mem_full", mem_full, 1'b1);
        check("full word_count", word_count, 6'd32);
        check("full inst_addr", inst_addr, 32'd31);
        check("full pulses", log_addr.size(), 32'd32);

        // Bytes in DONE are ignored; then a restart with a lone HALT word.
        clear_log();
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 8'($urandom()));
        check("done ignores bytes", log_addr.size(), 32'd0);
        tick(1'b1, 1'b0, 8'h00);
        send_word(32'hFFFF_FFFF);
        idle(1);
        check("restart word_count", word_count, 6'd1);
        check("restart load_done", load_done, 1'b1);
        check("restart mem_full", mem_full, 1'b0);
        check("restart pulses", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) check("restart addr", log_addr[0], 32'd0);

        // Asynchronous reset after two bytes aborts the word.
        clear_log();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'hDE);
        tick(1'b0, 1'b1, 8'hAD);
        #2 rst = 1'b0;
        model_reset();
        #1 compare();
        check("reset drops loading", loading, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 1'b0, 8'h00);
        send_word(32'h1234_5678);
        idle(1);
        check("post-reset pulses", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            check("post-reset addr", log_addr[0], 32'd0);
            check("post-reset data", log_data[0], 32'h1234_5678);
        end

        // Randomized loads: random gaps, stray starts, occasional HALT.
        for (int l = 0; l < 6; l++) begin
            int words;
            words = 0;
            if (!m_done) begin
                while (!m_done && words < DEPTH + 2) begin
                    send_word_gapped(($urandom_range(0, 7) == 0) ? HALT_WORD : non_halt_word());
                    words++;
                end
                idle(2);
            end
            tick(1'b1, ($urandom_range(0, 1) == 1), 8'($urandom()));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
